// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the divide unit.
// Holds the operand width, the M-extension divide-group funct3 codes and
// the divide sequencer state encoding.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Ports:
//   rem_i     partial remainder, XLEN+1 bits
//   quo_i     quotient/dividend shift register
//   divisor_i unsigned divisor magnitude
//   rem_o     next partial remainder
//   quo_o     next quotient register, new quotient bit in the LSB
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          unused_rem_msb;

  // The remainder entering a step is always below the divisor, so its top
  // bit is zero and the shifted value still fits in XLEN+1 bits.
  assign unused_rem_msb = rem_i[XLEN];
  assign shifted        = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
  // MSB of the trial difference is the borrow: set means the subtract failed.
  assign trial          = shifted - {1'b0, divisor_i};

  always_comb begin
    rem_o = shifted;
    quo_o = {quo_i[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      rem_o = trial;
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// RV32M divide-group unit (DIV, DIVU, REM, REMU) for the execute stage.
// Restoring shift-subtract, one quotient bit per cycle, with sign
// correction before and after the loop. Divide-by-zero and signed overflow
// complete directly from IDLE.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   start_i, funct3_i   request and operation select (sampled together)
//   op_a_i, op_b_i      dividend and divisor
//   flush_i             abort to IDLE, no completion
//   busy_o              not in IDLE
//   stall_o             hold request to the pipeline
//   done_o, result_o    one-cycle completion pulse and held result
//
// state  | meaning
// IDLE   | waiting for start_i; special cases finish from here
// PREP   | take magnitudes, record result signs, load loop
// CALC   | XLEN shift-subtract iterations
// FIX    | select quotient/remainder, apply sign, register result
// DONE   | done_o high for one cycle
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  import rv32_pkg::*;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [5:0]      CNT_LOAD = 6'(XLEN - 1);

  div_state_t      state;
  logic [1:0]      op_q;       // funct3[1:0]: bit1 = remainder, bit0 = unsigned
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;        // raw divisor, then its magnitude from PREP on
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [5:0]      cnt_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic [XLEN-1:0] result_q;
  logic            done_q;

  logic            accept;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_result;
  logic            op_signed;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] fix_result;
  logic            unused_funct3;

  assign unused_funct3 = funct3_i[2];
  assign accept        = start_i & ~flush_i;

  assign div_zero = (op_b_i == '0);
  assign overflow = ~funct3_i[0] & (op_a_i == MIN_NEG) & (op_b_i == ALL_ONES);
  assign special  = div_zero | overflow;

  always_comb begin
    special_result = '0;
    if (div_zero) special_result = funct3_i[1] ? op_a_i : ALL_ONES;
    else          special_result = funct3_i[1] ? '0     : MIN_NEG;
  end

  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude for the iterative loop.
  assign op_signed = ~op_q[0];
  assign abs_a     = (op_signed && a_q[XLEN-1]) ? -a_q : a_q;
  assign abs_b     = (op_signed && b_q[XLEN-1]) ? -b_q : b_q;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (b_q),
    .rem_o     (rem_nxt),
    .quo_o     (quo_nxt)
  );

  always_comb begin
    fix_result = quo_q;
    if (op_q[1]) fix_result = r_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    else         fix_result = q_neg_q ? -quo_q : quo_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              op_q <= funct3_i[1:0];
              a_q  <= op_a_i;
              b_q  <= op_b_i;
              if (special) begin
                result_q <= special_result;
                done_q   <= 1'b1;
                state    <= S_DONE;
              end else begin
                state <= S_PREP;
              end
            end
          end
          S_PREP: begin
            b_q     <= abs_b;
            quo_q   <= abs_a;
            rem_q   <= '0;
            q_neg_q <= op_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
            r_neg_q <= op_signed & a_q[XLEN-1];
            cnt_q   <= CNT_LOAD;
            state   <= S_CALC;
          end
          S_CALC: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd0) state <= S_FIX;
          end
          S_FIX: begin
            result_q <= fix_result;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy_o   = (state != S_IDLE);
  assign stall_o  = ((state == S_IDLE) && accept) ||
                    (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
